// File: rtl/pmesh_l2_msg_sched.sv
// rtl/pmesh_l2_msg_sched.sv - PMESH L2 ingress scheduler for msg1/msg3 into one transaction slot
//
// Purpose: arbitrates the request (msg1) and response (msg3) channels into a
// single L2 pipeline slot and sequences each transaction through issue,
// completion, an optional msg2 reply and an optional wait for a forward ack.
// Only one transaction is in flight at a time.
//
// Parameters:
//   STARVE_MAX  - consecutive msg3 grants while msg1 waits before msg1 wins
//   ACK_TIMEOUT - WAIT_ACK watchdog limit in cycles
//
// Optional feature macro: PMESH_L2_SCHED_ACK_TIMEOUT_EN enables the WAIT_ACK
// watchdog (wd_cnt, sticky ack_timeout). Without it WAIT_ACK waits forever.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   msg1_* / msg3_*              request / response channels (ready is combinational)
//   pipe_valid, pipe_chan, pipe_* slot contents presented to the L2 pipe
//   pipe_done, pipe_need_ack,
//   pipe_ack_match, pipe_reply_* completion pulse and its qualifiers
//   msg2_valid/type/ready        reply channel
//   fsm_state                    0 IDLE, 1 ISSUE, 2 WAIT_ACK, 3 REPLY
//   ack_pend, ack_timeout        pending forward ack, sticky watchdog flag
module pmesh_l2_msg_sched #(
    parameter int STARVE_MAX  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        msg1_valid,
    output logic        msg1_ready,
    input  logic [7:0]  msg1_type,
    input  logic [5:0]  msg1_source,
    input  logic [25:0] msg1_tag,
    input  logic [63:0] msg1_data,
    input  logic        msg3_valid,
    output logic        msg3_ready,
    input  logic [7:0]  msg3_type,
    input  logic [5:0]  msg3_source,
    input  logic [25:0] msg3_tag,
    input  logic [63:0] msg3_data,
    output logic        pipe_valid,
    output logic        pipe_chan,
    output logic [7:0]  pipe_type,
    output logic [5:0]  pipe_source,
    output logic [25:0] pipe_tag,
    output logic [63:0] pipe_data,
    input  logic        pipe_done,
    input  logic        pipe_need_ack,
    input  logic        pipe_ack_match,
    input  logic        pipe_reply_vld,
    input  logic [7:0]  pipe_reply_typ,
    output logic        msg2_valid,
    output logic [7:0]  msg2_type,
    input  logic        msg2_ready,
    output logic [1:0]  fsm_state,
    output logic        ack_pend,
    output logic        ack_timeout
);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;
    localparam logic [1:0] ST_REPLY    = 2'd3;
    localparam logic [2:0] STARVE_LIM  = 3'(STARVE_MAX);

    logic [1:0]  state_q, state_d;
    logic        ack_pend_q, ack_pend_d, ack_next;
    logic [2:0]  starve_q, starve_d;
    logic        pipe_valid_q, pipe_valid_d;
    logic        pipe_chan_q, pipe_chan_d;
    logic [7:0]  pipe_type_q, pipe_type_d;
    logic [5:0]  pipe_source_q, pipe_source_d;
    logic [25:0] pipe_tag_q, pipe_tag_d;
    logic [63:0] pipe_data_q, pipe_data_d;
    logic        msg2_valid_q, msg2_valid_d;
    logic [7:0]  msg2_type_q, msg2_type_d;
    logic        grant1, grant3;
    logic        wd_expire;

    // Readies only assert when the matching valid is high, so a ready is a handshake.
    always_comb begin
        grant1 = 1'b0;
        grant3 = 1'b0;
        if (!rst) begin
            if (state_q == ST_IDLE) begin
                grant3 = msg3_valid & (~msg1_valid | (starve_q < STARVE_LIM));
                grant1 = msg1_valid & ~grant3;
            end else if (state_q == ST_WAIT_ACK) begin
                grant3 = msg3_valid;
            end
        end
    end

`ifdef PMESH_L2_SCHED_ACK_TIMEOUT_EN
    localparam logic [7:0] ACK_LIMIT = 8'(ACK_TIMEOUT);
    logic [7:0] wd_q, wd_d;
    logic       tmo_q;

    // Counter is held at zero outside WAIT_ACK, so every entry starts from 0.
    assign wd_d      = (state_q == ST_WAIT_ACK) ? wd_q + 8'd1 : 8'd0;
    assign wd_expire = (state_q == ST_WAIT_ACK) && (wd_q == ACK_LIMIT) && !grant3;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= 8'd0;
            tmo_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (wd_expire) begin
                tmo_q <= 1'b1;
            end
        end
    end
    assign ack_timeout = tmo_q;
`else
    logic [7:0] unused_ack_limit;
    assign unused_ack_limit = 8'(ACK_TIMEOUT);
    assign wd_expire        = 1'b0;
    assign ack_timeout      = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        ack_pend_d    = ack_pend_q;
        ack_next      = ack_pend_q;
        starve_d      = starve_q;
        pipe_valid_d  = pipe_valid_q;
        pipe_chan_d   = pipe_chan_q;
        pipe_type_d   = pipe_type_q;
        pipe_source_d = pipe_source_q;
        pipe_tag_d    = pipe_tag_q;
        pipe_data_d   = pipe_data_q;
        msg2_valid_d  = msg2_valid_q;
        msg2_type_d   = msg2_type_q;
        case (state_q)
            ST_IDLE, ST_WAIT_ACK: begin
                if (grant1 || grant3) begin
                    state_d       = ST_ISSUE;
                    pipe_valid_d  = 1'b1;
                    pipe_chan_d   = grant3;
                    pipe_type_d   = grant3 ? msg3_type   : msg1_type;
                    pipe_source_d = grant3 ? msg3_source : msg1_source;
                    pipe_tag_d    = grant3 ? msg3_tag    : msg1_tag;
                    pipe_data_d   = grant3 ? msg3_data   : msg1_data;
                    // Starvation only accrues from IDLE arbitration; WAIT_ACK leaves it alone.
                    if (grant1) begin
                        starve_d = 3'd0;
                    end else if (state_q == ST_IDLE && msg1_valid && starve_q < STARVE_LIM) begin
                        starve_d = starve_q + 3'd1;
                    end
                end else if (wd_expire) begin
                    ack_pend_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (pipe_done) begin
                    pipe_valid_d = 1'b0;
                    if (!pipe_chan_q && pipe_need_ack) begin
                        ack_next = 1'b1;
                    end else if (pipe_chan_q && pipe_ack_match) begin
                        ack_next = 1'b0;
                    end
                    ack_pend_d = ack_next;
                    if (pipe_reply_vld) begin
                        state_d      = ST_REPLY;
                        msg2_valid_d = 1'b1;
                        msg2_type_d  = pipe_reply_typ;
                    end else if (ack_next) begin
                        state_d = ST_WAIT_ACK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                if (msg2_ready) begin
                    msg2_valid_d = 1'b0;
                    state_d      = ack_pend_q ? ST_WAIT_ACK : ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ack_pend_q    <= 1'b0;
            starve_q      <= 3'd0;
            pipe_valid_q  <= 1'b0;
            pipe_chan_q   <= 1'b0;
            pipe_type_q   <= 8'd0;
            pipe_source_q <= 6'd0;
            pipe_tag_q    <= 26'd0;
            pipe_data_q   <= 64'd0;
            msg2_valid_q  <= 1'b0;
            msg2_type_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            ack_pend_q    <= ack_pend_d;
            starve_q      <= starve_d;
            pipe_valid_q  <= pipe_valid_d;
            pipe_chan_q   <= pipe_chan_d;
            pipe_type_q   <= pipe_type_d;
            pipe_source_q <= pipe_source_d;
            pipe_tag_q    <= pipe_tag_d;
            pipe_data_q   <= pipe_data_d;
            msg2_valid_q  <= msg2_valid_d;
            msg2_type_q   <= msg2_type_d;
        end
    end

    assign msg1_ready  = grant1;
    assign msg3_ready  = grant3;
    assign pipe_valid  = pipe_valid_q;
    assign pipe_chan   = pipe_chan_q;
    assign pipe_type   = pipe_type_q;
    assign pipe_source = pipe_source_q;
    assign pipe_tag    = pipe_tag_q;
    assign pipe_data   = pipe_data_q;
    assign msg2_valid  = msg2_valid_q;
    assign msg2_type   = msg2_type_q;
    assign fsm_state   = state_q;
    assign ack_pend    = ack_pend_q;
endmodule

// File: tb/tb_pmesh_l2_msg_sched.sv
// tb/tb_pmesh_l2_msg_sched.sv - self-checking bench for pmesh_l2_msg_sched
module tb_pmesh_l2_msg_sched;
    localparam int STARVE_MAX  = 4;
    localparam int ACK_TIMEOUT = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        msg1_valid, msg1_ready, msg3_valid, msg3_ready;
    logic [7:0]  msg1_type, msg3_type, pipe_type, pipe_reply_typ, msg2_type;
    logic [5:0]  msg1_source, msg3_source, pipe_source;
    logic [25:0] msg1_tag, msg3_tag, pipe_tag;
    logic [63:0] msg1_data, msg3_data, pipe_data;
    logic        pipe_valid, pipe_chan, pipe_done, pipe_need_ack, pipe_ack_match, pipe_reply_vld;
    logic        msg2_valid, msg2_ready, ack_pend, ack_timeout;
    logic [1:0]  fsm_state;

    pmesh_l2_msg_sched #(.STARVE_MAX(STARVE_MAX), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .msg1_valid(msg1_valid), .msg1_ready(msg1_ready), .msg1_type(msg1_type),
        .msg1_source(msg1_source), .msg1_tag(msg1_tag), .msg1_data(msg1_data),
        .msg3_valid(msg3_valid), .msg3_ready(msg3_ready), .msg3_type(msg3_type),
        .msg3_source(msg3_source), .msg3_tag(msg3_tag), .msg3_data(msg3_data),
        .pipe_valid(pipe_valid), .pipe_chan(pipe_chan), .pipe_type(pipe_type),
        .pipe_source(pipe_source), .pipe_tag(pipe_tag), .pipe_data(pipe_data),
        .pipe_done(pipe_done), .pipe_need_ack(pipe_need_ack), .pipe_ack_match(pipe_ack_match),
        .pipe_reply_vld(pipe_reply_vld), .pipe_reply_typ(pipe_reply_typ),
        .msg2_valid(msg2_valid), .msg2_type(msg2_type), .msg2_ready(msg2_ready),
        .fsm_state(fsm_state), .ack_pend(ack_pend), .ack_timeout(ack_timeout)
    );

    int checks = 0;
    int errors = 0;

    task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
        errors++;
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fail(name, act, exp);
        end
    endtask

    bit          mon_en = 1'b0;
    bit          m_busy, m_chan, m_reply, m_ack, m_tmo;
    logic [7:0]  m_type, m_rtype;
    logic [5:0]  m_src;
    logic [25:0] m_tag;
    logic [63:0] m_data;
    int          m_starve = 0;
    int          m_wait = 0;
    bit          e1, e3;
    int          efsm;

    always begin
        @(negedge clk);
        if (mon_en) begin
            e1 = 1'b0;
            e3 = 1'b0;
            if (!rst && !m_busy && !m_reply) begin
                if (m_ack) begin
                    e3 = msg3_valid;
                end else begin
                    e3 = msg3_valid && (!msg1_valid || m_starve < STARVE_MAX);
                    e1 = msg1_valid && !e3;
                end
            end
            efsm = m_reply ? 3 : (m_busy ? 1 : (m_ack ? 2 : 0));
            checks += 7;
            if (msg1_ready !== e1) fail("msg1_ready", 64'(msg1_ready), 64'(e1));
            if (msg3_ready !== e3) fail("msg3_ready", 64'(msg3_ready), 64'(e3));
            if (pipe_valid !== m_busy) fail("pipe_valid", 64'(pipe_valid), 64'(m_busy));
            if (msg2_valid !== m_reply) fail("msg2_valid", 64'(msg2_valid), 64'(m_reply));
            if (32'(fsm_state) !== efsm) fail("fsm_state", 64'(fsm_state), 64'(efsm));
            if (ack_pend !== m_ack) fail("ack_pend", 64'(ack_pend), 64'(m_ack));
            if (ack_timeout !== m_tmo) fail("ack_timeout", 64'(ack_timeout), 64'(m_tmo));
            if (m_busy) begin
                checks += 5;
                if (pipe_chan !== m_chan) fail("pipe_chan", 64'(pipe_chan), 64'(m_chan));
                if (pipe_type !== m_type) fail("pipe_type", 64'(pipe_type), 64'(m_type));
                if (pipe_source !== m_src) fail("pipe_source", 64'(pipe_source), 64'(m_src));
                if (pipe_tag !== m_tag) fail("pipe_tag", 64'(pipe_tag), 64'(m_tag));
                if (pipe_data !== m_data) fail("pipe_data", pipe_data, m_data);
            end
            if (m_reply) begin
                checks++;
                if (msg2_type !== m_rtype) fail("msg2_type", 64'(msg2_type), 64'(m_rtype));
            end
            if (rst) begin
                m_busy = 0; m_reply = 0; m_ack = 0; m_tmo = 0; m_starve = 0; m_wait = 0;
            end else if (m_reply) begin
                m_wait = 0;
                if (msg2_ready) m_reply = 0;
            end else if (m_busy) begin
                m_wait = 0;
                if (pipe_done) begin
                    m_busy = 0;
                    if (!m_chan && pipe_need_ack) m_ack = 1;
                    if (m_chan && pipe_ack_match) m_ack = 0;
                    if (pipe_reply_vld) begin
                        m_reply = 1;
                        m_rtype = pipe_reply_typ;
                    end
                end
            end else if (e1 || e3) begin
                m_wait = 0;
                m_busy = 1;
                m_chan = e3;
                m_type = e3 ? msg3_type : msg1_type;
                m_src  = e3 ? msg3_source : msg1_source;
                m_tag  = e3 ? msg3_tag : msg1_tag;
                m_data = e3 ? msg3_data : msg1_data;
                if (e1) m_starve = 0;
                else if (!m_ack && msg1_valid && m_starve < STARVE_MAX) m_starve++;
            end else if (m_ack) begin
`ifdef PMESH_L2_SCHED_ACK_TIMEOUT_EN
                if (m_wait == ACK_TIMEOUT) begin
                    m_tmo = 1; m_ack = 0; m_wait = 0;
                end else begin
                    m_wait++;
                end
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        msg1_valid = 0; msg3_valid = 0; pipe_done = 0; pipe_need_ack = 0;
        pipe_ack_match = 0; pipe_reply_vld = 0; pipe_reply_typ = 8'h00; msg2_ready = 0;
    endtask

    task automatic enter_wait_ack(input string tag);
        step; msg1_valid = 1; msg1_type = 8'h07;
        @(negedge clk); chk({tag, "_grant"}, 64'(msg1_ready), 64'(1));
        step; msg1_valid = 0; pipe_done = 1; pipe_need_ack = 1;
        @(negedge clk);
        step; pipe_done = 0; pipe_need_ack = 0;
        @(negedge clk); chk({tag, "_in_wait"}, 64'(fsm_state), 64'(2));
    endtask

    int ng, nv, nw;
    bit [5:0] chans;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stalled expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1; clear_inputs();
        msg1_type = 8'h01; msg1_source = 6'h05; msg1_tag = 26'h123456; msg1_data = 64'hA5A5_0000_1111_2222;
        msg3_type = 8'h16; msg3_source = 6'h2A; msg3_tag = 26'h0ABCDE; msg3_data = 64'h5A5A_3333_4444_5555;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1; msg1_valid = 1; msg3_valid = 1;
        @(negedge clk);
        chk("rst_msg1_ready", 64'(msg1_ready), 64'(0));
        chk("rst_msg3_ready", 64'(msg3_ready), 64'(0));
        chk("rst_state", 64'(fsm_state), 64'(0));
        chk("rst_pipe_valid", 64'(pipe_valid), 64'(0));
        chk("rst_msg2", 64'({msg2_valid, msg2_type}), 64'(0));
        chk("rst_flags", 64'({ack_pend, ack_timeout}), 64'(0));
        step; rst = 0; clear_inputs();
        @(negedge clk);

        step; msg1_valid = 1; msg1_type = 8'h01;
        @(negedge clk); chk("t1_msg1_ready", 64'(msg1_ready), 64'(1)); chk("t1_msg3_ready", 64'(msg3_ready), 64'(0));
        step; msg1_valid = 0; pipe_done = 1;
        @(negedge clk); chk("t1_issue", 64'(fsm_state), 64'(1)); chk("t1_chan", 64'(pipe_chan), 64'(0));
        chk("t1_type", 64'(pipe_type), 64'(8'h01));
        step; pipe_done = 0;
        @(negedge clk); chk("t1_idle", 64'(fsm_state), 64'(0)); chk("t1_pipe_valid", 64'(pipe_valid), 64'(0));

        step; msg1_valid = 1; msg3_valid = 1; pipe_done = 1;
        ng = 0; chans = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            @(negedge clk);
            if (msg1_ready || msg3_ready) begin
                chans[ng] = msg3_ready;
                ng++;
            end
            step;
        end
        msg1_valid = 0; msg3_valid = 0;
        chk("t2_grants", 64'(ng), 64'(6));
        chk("t2_order", 64'(chans), 64'(6'b101111));
        @(negedge clk);
        step; pipe_done = 0;
        @(negedge clk);

        step; msg1_valid = 1; msg1_type = 8'h20;
        @(negedge clk); chk("t3_grant1", 64'(msg1_ready), 64'(1));
        step; pipe_done = 1; pipe_need_ack = 1;
        @(negedge clk); chk("t3_issue", 64'(fsm_state), 64'(1)); chk("t3_issue_rdy", 64'(msg1_ready), 64'(0));
        step; pipe_done = 0; pipe_need_ack = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t3_wait_state", 64'(fsm_state), 64'(2));
            chk("t3_wait_pend", 64'(ack_pend), 64'(1));
            chk("t3_wait_rdy1", 64'(msg1_ready), 64'(0));
            step;
        end
        msg3_valid = 1; msg3_type = 8'h16;
        @(negedge clk); chk("t3_grant3", 64'(msg3_ready), 64'(1)); chk("t3_block1", 64'(msg1_ready), 64'(0));
        step; msg3_valid = 0; pipe_done = 1; pipe_ack_match = 1;
        @(negedge clk); chk("t3_chan", 64'(pipe_chan), 64'(1)); chk("t3_type", 64'(pipe_type), 64'(8'h16));
        step; pipe_done = 0; pipe_ack_match = 0;
        @(negedge clk); chk("t3_idle", 64'(fsm_state), 64'(0)); chk("t3_pend_clr", 64'(ack_pend), 64'(0));
        chk("t3_msg1_next", 64'(msg1_ready), 64'(1));
        step; msg1_valid = 0; pipe_done = 1;
        @(negedge clk);
        step; pipe_done = 0;
        @(negedge clk);

        step; msg1_valid = 1; msg1_type = 8'h02;
        @(negedge clk); chk("t4_grant", 64'(msg1_ready), 64'(1));
        step; msg1_valid = 0; pipe_done = 1; pipe_reply_vld = 1; pipe_reply_typ = 8'h16;
        @(negedge clk);
        step; pipe_done = 0; pipe_reply_vld = 0; pipe_reply_typ = 8'h00;
        nv = 0;
        for (int c = 0; c < 4; c++) begin
            msg2_ready = (c == 3);
            @(negedge clk);
            if (msg2_valid) nv++;
            chk("t4_type", 64'(msg2_type), 64'(8'h16));
            chk("t4_state", 64'(fsm_state), 64'(3));
            step;
        end
        msg2_ready = 0;
        @(negedge clk);
        chk("t4_valid_cycles", 64'(nv), 64'(4)); chk("t4_drop", 64'(msg2_valid), 64'(0));
        chk("t4_idle", 64'(fsm_state), 64'(0));

        step; msg1_valid = 1;
        @(negedge clk);
        step; msg1_valid = 0; pipe_done = 1; pipe_reply_vld = 1; pipe_reply_typ = 8'h33;
        @(negedge clk);
        step; pipe_done = 0; pipe_reply_vld = 0;
        @(negedge clk); chk("t5a_reply", 64'(fsm_state), 64'(3));
        step; rst = 1; msg1_valid = 1; msg3_valid = 1;
        @(negedge clk); chk("t5a_rdy", 64'({msg1_ready, msg3_ready}), 64'(0));
        step; rst = 0; msg1_valid = 0; msg3_valid = 0;
        @(negedge clk); chk("t5a_state", 64'(fsm_state), 64'(0)); chk("t5a_msg2", 64'(msg2_valid), 64'(0));
        chk("t5a_pipe", 64'(pipe_valid), 64'(0));
        enter_wait_ack("t5b");
        step; rst = 1; msg3_valid = 1;
        @(negedge clk); chk("t5b_rdy", 64'(msg3_ready), 64'(0));
        step; rst = 0; msg3_valid = 0;
        @(negedge clk); chk("t5b_state", 64'(fsm_state), 64'(0)); chk("t5b_pend", 64'(ack_pend), 64'(0));

`ifdef PMESH_L2_SCHED_ACK_TIMEOUT_EN
        enter_wait_ack("t6");
        nw = 1;
        for (int c = 0; c < 40; c++) begin
            step;
            @(negedge clk);
            if (ack_timeout) break;
            if (fsm_state == 2) nw++;
        end
        chk("t6_wait_cycles", 64'(nw), 64'(ACK_TIMEOUT + 1));
        chk("t6_flag", 64'(ack_timeout), 64'(1)); chk("t6_idle", 64'(fsm_state), 64'(0));
        repeat (3) step;
        @(negedge clk); chk("t6_sticky", 64'(ack_timeout), 64'(1));
`endif

        for (int c = 0; c < 4000; c++) begin
            step;
            rst            = ($urandom_range(0, 199) == 0);
            msg1_valid     = 1'($urandom_range(0, 1));
            msg3_valid     = 1'($urandom_range(0, 1));
            msg1_type      = 8'($urandom);  msg3_type   = 8'($urandom);
            msg1_source    = 6'($urandom);  msg3_source = 6'($urandom);
            msg1_tag       = 26'($urandom); msg3_tag    = 26'($urandom);
            msg1_data      = {$urandom, $urandom};
            msg3_data      = {$urandom, $urandom};
            pipe_done      = ($urandom_range(0, 9) < 4);
            pipe_need_ack  = 1'($urandom_range(0, 1));
            pipe_ack_match = 1'($urandom_range(0, 1));
            pipe_reply_vld = ($urandom_range(0, 9) < 3);
            pipe_reply_typ = 8'($urandom);
            msg2_ready     = 1'($urandom_range(0, 1));
        end
        step; rst = 0; clear_inputs();
        repeat (2) step;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
